// File: rtl/chan_mux_pkg.sv
// rtl/chan_mux_pkg.sv - shared mode encodings and index helpers for chan_mux_reg
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   MAX_N      = 32;

  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i == idx && i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Pointer to the channel after c, wrapping at n-1 (n need not be a power of 2).
  function automatic int next_ptr(input int c, input int n);
    return (c == n - 1) ? 0 : c + 1;
  endfunction

endpackage

// File: rtl/chan_mux_reg_rr_pick.sv
// rtl/chan_mux_reg_rr_pick.sv - combinational round-robin search starting at ptr
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  // Pass one finds the lowest requester overall (the wrap-around answer);
  // pass two overrides it with the lowest requester at or above ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (req[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'(c);
      end
    end
    for (int c = N - 1; c >= 0; c--) begin
      if (req[c] && c >= int'(ptr)) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/chan_mux_reg.sv
// rtl/chan_mux_reg.sv - N-channel registered mux with valid/ready; CHAN_MUX_PARITY_EN adds out_par
module chan_mux_reg
  import chan_mux_pkg::*;
#(
  parameter  int W    = 4,
  parameter  int N    = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in1,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  output logic [W-1:0]    out,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
`ifdef CHAN_MUX_PARITY_EN
  output logic            out_par,
`endif
  input  logic            out_ready
);

  logic [W-1:0]    out_q, out_d;
  logic [SELW-1:0] chan_q, chan_d;
  logic            valid_q, valid_d;
  logic [SELW-1:0] ptr_q, ptr_d;
`ifdef CHAN_MUX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic            fix_vld;
  logic            grant;
  logic            load;
  logic [SELW-1:0] gnt_idx;
  logic [W-1:0]    gnt_data;

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Fixed select compares against every legal index so sel >= N never grants.
  always_comb begin
    fix_vld = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (int'(sel) == c && in_valid[c]) fix_vld = 1'b1;
    end
  end

  always_comb begin
    load    = !valid_q || out_ready;
    grant   = rst_n && ((mode == MODE_RR) ? rr_vld : fix_vld);
    gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int c = 0; c < N; c++) begin
      if (int'(gnt_idx) == c) begin
        in_ready[c] = load && grant;
        gnt_data    = in1[c*W +: W];
      end
    end
  end

  always_comb begin
    out_d   = out_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef CHAN_MUX_PARITY_EN
    par_d   = par_q;
`endif
    if (load) begin
      if (grant) begin
        out_d   = gnt_data;
        chan_d  = gnt_idx;
        valid_d = 1'b1;
        ptr_d   = SELW'(next_ptr(int'(gnt_idx), N));
`ifdef CHAN_MUX_PARITY_EN
        par_d   = ^gnt_data;
`endif
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef CHAN_MUX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      out_q   <= out_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef CHAN_MUX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
`ifdef CHAN_MUX_PARITY_EN
  assign out_par   = par_q;
`endif

endmodule

// File: tb/tb_chan_mux_reg.sv
// tb/tb_chan_mux_reg.sv - scoreboard bench for chan_mux_reg (W=4, N=4)
module tb_chan_mux_reg;

  logic        clk;
  logic        rst_n;
  logic [15:0] in1;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  out;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
`ifdef CHAN_MUX_PARITY_EN
  logic        out_par;
`endif

  chan_mux_reg #(.W(4), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out       (out),
    .out_chan  (out_chan),
    .out_valid (out_valid),
`ifdef CHAN_MUX_PARITY_EN
    .out_par   (out_par),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] ch;
  } word_t;

  word_t      exp_q[$];
  word_t      w;
  int         checks;
  int         failures;
  logic       m_full;
  int         m_ptr;
  logic [3:0] last_out;
  logic [1:0] last_chan;

  function automatic void model_grant(output logic vld, output int idx);
    vld = 1'b0;
    idx = 0;
    if (mode == 1'b0) begin
      if (in_valid[sel]) begin
        vld = 1'b1;
        idx = int'(sel);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!vld && in_valid[c]) begin
          vld = 1'b1;
          idx = c;
        end
      end
    end
  endfunction

  function automatic logic [3:0] exp_ready();
    logic g;
    int   c;
    model_grant(g, c);
    if (rst_n && g && (!m_full || out_ready)) return 4'(1 << c);
    return 4'b0000;
  endfunction

  // Updates the reference model for the upcoming edge, then steps to the next negedge.
  task automatic advance();
    logic g;
    int   c;
    model_grant(g, c);
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
    end else if (!m_full || out_ready) begin
      if (g) begin
        exp_q.push_back({in1[c*4 +: 4], 2'(c)});
        m_full = 1'b1;
        m_ptr  = (c == 3) ? 0 : c + 1;
      end else begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    last_out  = 4'b0000;
    last_chan = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; mode = 1'b1; sel = 2'd1; in1 = 16'hABCD;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
      end
      advance();
    end
    checks++;
    if (out !== 4'b0000 || out_chan !== 2'b00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got out=%b chan=%b valid=%b expected 0000/00/0", out, out_chan, out_valid);
    end
    rst_n = 1'b1;
    last_out  = 4'b0000;
    last_chan = 2'b00;
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in1 = 16'b1111_1111_0001_0000; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++; $display("FAIL fixed_in_ready: got %b expected 0010", in_ready);
    end
    advance();
    checks++;
    if (exp_q.size() == 0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL fixed_out_valid: got %b expected 1 (queued=%0d)", out_valid, exp_q.size());
      exp_q.delete();
    end else begin
      w = exp_q.pop_front();
      checks++;
      if (out !== w.d || out_chan !== w.ch) begin
        failures++; $display("FAIL fixed_word: got %b/%b expected %b/%b", out, out_chan, w.d, w.ch);
      end
      last_out = w.d; last_chan = w.ch;
    end
  endtask

  task automatic test_no_grant();
    sel = 2'd2; in_valid = 4'b0001;
    #1;
    checks++;
    if (in_ready !== exp_ready() || in_ready !== 4'b0000) begin
      failures++; $display("FAIL nogrant_in_ready: got %b expected 0000", in_ready);
    end
    advance();
    checks++;
    if (out_valid !== 1'b0 || out !== last_out || out_chan !== last_chan) begin
      failures++;
      $display("FAIL nogrant_hold: got %b/%b valid=%b expected %b/%b valid=0", out, out_chan, out_valid, last_out, last_chan);
    end
  endtask

  task automatic test_stall();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in1 = 16'h0005; out_ready = 1'b1;
    advance();
    w = exp_q.pop_front();
    checks++;
    if (out !== w.d || out_chan !== w.ch || out_valid !== 1'b1) begin
      failures++; $display("FAIL stall_load: got %b/%b expected %b/%b", out, out_chan, w.d, w.ch);
    end
    last_out = w.d; last_chan = w.ch;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in1 = 16'($urandom); sel = 2'($urandom); in_valid = 4'hF;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL stall_in_ready: got %b expected 0000", in_ready);
      end
      advance();
      checks++;
      if (out !== last_out || out_chan !== last_chan || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold: got %b/%b valid=%b expected %b/%b valid=1", out, out_chan, out_valid, last_out, last_chan);
      end
    end
    out_ready = 1'b1; sel = 2'd2; in_valid = 4'b0100; in1 = 16'h0900;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++; $display("FAIL release_in_ready: got %b expected 0100", in_ready);
    end
    advance();
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL release_word: got no grant expected 1001/10");
    end else begin
      w = exp_q.pop_front();
      if (out !== w.d || out_chan !== w.ch || out_valid !== 1'b1) begin
        failures++; $display("FAIL release_word: got %b/%b expected %b/%b", out, out_chan, w.d, w.ch);
      end
      last_out = w.d; last_chan = w.ch;
    end
  endtask

  task automatic test_round_robin();
    int seq_a[5] = '{0, 1, 2, 3, 0};
    int seq_b[3] = '{1, 3, 1};
    reset_dut();
    mode = 1'b1; in_valid = 4'hF; in1 = 16'h3210; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) in_valid = 4'b1010;
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", i, in_ready, exp_ready());
      end
      advance();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL rr_word[%0d]: got no grant expected a word", i);
      end else begin
        w = exp_q.pop_front();
        if (out !== w.d || out_chan !== w.ch || out_valid !== 1'b1 ||
            int'(out_chan) != ((i < 5) ? seq_a[i] : seq_b[i-5])) begin
          failures++; $display("FAIL rr_word[%0d]: got %b/%b expected %b/%b", i, out, out_chan, w.d, w.ch);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++; $display("FAIL midreset_in_ready: got %b expected 0000", in_ready);
    end
    advance();
    checks++;
    if (out_valid !== 1'b0 || out !== 4'b0000) begin
      failures++; $display("FAIL midreset_state: got %b valid=%b expected 0000 valid=0", out, out_valid);
    end
    rst_n = 1'b1;
    last_out = 4'b0000; last_chan = 2'b00;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      mode = 1'($urandom); sel = 2'($urandom); in_valid = 4'($urandom);
      in1 = 16'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++; $display("FAIL b2b_in_ready[%0d]: got %b expected %b", i, in_ready, exp_ready());
      end
      advance();
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        last_out = w.d; last_chan = w.ch;
      end
      checks++;
      if (out_valid !== m_full || out !== last_out || out_chan !== last_chan) begin
        failures++;
        $display("FAIL b2b_out[%0d]: got %b/%b valid=%b expected %b/%b valid=%b", i, out, out_chan, out_valid, last_out, last_chan, m_full);
      end
    end
  endtask

`ifdef CHAN_MUX_PARITY_EN
  task automatic test_parity();
    logic [3:0] pats[2] = '{4'b0111, 4'b0011};
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in1 = {12'h000, pats[i]};
      advance();
      if (exp_q.size() > 0) w = exp_q.pop_front();
      checks++;
      if (out_par !== ^w.d || out !== w.d) begin
        failures++; $display("FAIL parity[%0d]: got out=%b par=%b expected out=%b par=%b", i, out, out_par, w.d, ^w.d);
      end
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0; m_full = 1'b0; m_ptr = 0;
    rst_n = 1'b0; in1 = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
    last_out = '0; last_chan = '0;
    @(negedge clk);
    test_reset();
    test_fixed();
    test_no_grant();
    test_stall();
    test_round_robin();
    test_reset_mid();
    test_back_to_back();
`ifdef CHAN_MUX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
